// File: rtl/par_fifo.sv
// Parallel-port FIFO: PAR_WRITE words in per accepted write, PAR_READ words out per accepted read.
// Flags decode the occupancy count; dout is registered and holds until the next accepted read.
module par_fifo #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAR_WRITE  = 4,
  parameter int unsigned PAR_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clear,
  input  logic                           wen,
  input  logic                           ren,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
  output logic [PAR_READ*DATA_WIDTH-1:0]  dout,
  output logic                           full,
  output logic                           empty,
  output logic                           ready,
  output logic                           valid
);

  localparam int unsigned Depth      = 2 ** ADDR_WIDTH;
  localparam int unsigned CountWidth = ADDR_WIDTH + 1;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [CountWidth-1:0] cnt_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                          mem_q [Depth];
  ptr_t                           wptr_q, wptr_d;
  ptr_t                           rptr_q, rptr_d;
  cnt_t                           count_q, count_d;
  logic [PAR_READ*DATA_WIDTH-1:0] dout_q, dout_d;
  ptr_t                           wr_addr [PAR_WRITE];
  ptr_t                           rd_addr [PAR_READ];
  logic                           wr_acc, rd_acc;

  // Flags depend on count only.
  always_comb begin
    full  = (count_q == cnt_t'(Depth));
    empty = (count_q == '0);
    ready = ((cnt_t'(Depth) - count_q) >= cnt_t'(PAR_WRITE));
    valid = (count_q >= cnt_t'(PAR_READ));
  end

  // clear takes priority over both ports in the same cycle.
  always_comb begin
    wr_acc = wen & ready & ~clear;
    rd_acc = ren & valid & ~clear;
  end

  // Pointer arithmetic is ADDR_WIDTH wide, so multi-word accesses wrap past Depth-1 for free.
  always_comb begin
    for (int unsigned i = 0; i < PAR_WRITE; i++) begin
      wr_addr[i] = wptr_q + ptr_t'(i);
    end
    for (int unsigned j = 0; j < PAR_READ; j++) begin
      rd_addr[j] = rptr_q + ptr_t'(j);
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      dout_d  = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + ptr_t'(PAR_WRITE);
      end
      if (rd_acc) begin
        rptr_d = rptr_q + ptr_t'(PAR_READ);
        for (int unsigned j = 0; j < PAR_READ; j++) begin
          dout_d[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[j]];
        end
      end
      count_d = count_q + (wr_acc ? cnt_t'(PAR_WRITE) : cnt_t'(0))
                        - (rd_acc ? cnt_t'(PAR_READ)  : cnt_t'(0));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage has no reset; a simultaneous read sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned i = 0; i < PAR_WRITE; i++) begin
        mem_q[wr_addr[i]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_par_fifo.sv
// Bench for par_fifo: directed scenarios then random traffic, checked against a word-queue model.
module tb_par_fifo;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned PW    = 4;
  localparam int unsigned PR    = 2;
  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              clear;
  logic              wen;
  logic              ren;
  logic [PW*DW-1:0]  din;
  logic [PR*DW-1:0]  dout;
  logic              full;
  logic              empty;
  logic              ready;
  logic              valid;

  par_fifo #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .PAR_WRITE (PW),
    .PAR_READ  (PR)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .clear(clear),
    .wen  (wen),
    .ren  (ren),
    .din  (din),
    .dout (dout),
    .full (full),
    .empty(empty),
    .ready(ready),
    .valid(valid)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is just an ordered list of words plus the last read result.
  logic [DW-1:0]    q[$];
  logic [PR*DW-1:0] m_dout;
  int               n_pass;
  int               n_fail;
  int               n_total;

  function automatic logic [3:0] exp_flags();
    int n;
    n = q.size();
    return {n == DEPTH, n == 0, (DEPTH - n) >= PW, n >= PR};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " flags"}, 64'({full, empty, ready, valid}), 64'(exp_flags()));
    check({tag, " dout"}, 64'(dout), 64'(m_dout));
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [PW*DW-1:0] d);
    bit wa;
    bit ra;
    wen   = w;
    ren   = r;
    clear = c;
    din   = d;
    wa = w && !c && ((DEPTH - q.size()) >= PW);
    ra = r && !c && (q.size() >= PR);
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      m_dout = '0;
    end else begin
      if (ra) begin
        for (int j = 0; j < PR; j++) m_dout[j*DW +: DW] = q.pop_front();
      end
      if (wa) begin
        for (int i = 0; i < PW; i++) q.push_back(d[i*DW +: DW]);
      end
    end
    wen   = 1'b0;
    ren   = 1'b0;
    clear = 1'b0;
  endtask

  // Reset pulse placed between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    q.delete();
    m_dout = '0;
    check({tag, " async flags"}, 64'({full, empty, ready, valid}), 64'(4'b0110));
    check({tag, " async dout"}, 64'(dout), 64'h0);
    #1 rstn = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    m_dout  = '0;
    rstn    = 1'b0;
    clear   = 1'b0;
    wen     = 1'b0;
    ren     = 1'b0;
    din     = '0;
    #12;
    check("reset flags", 64'({full, empty, ready, valid}), 64'(4'b0110));
    check("reset dout", 64'(dout), 64'h0);
    rstn = 1'b1;

    // Basic write then read
    step(1, 0, 0, 32'hA2_34_98_AC);
    check_state("w1");
    check("w1 flags const", 64'({full, empty, ready, valid}), 64'(4'b0011));
    step(0, 1, 0, '0);
    check("r1 dout", 64'(dout), 64'h98AC);
    check_state("r1");

    // Fill to 6, dropped write, read
    step(1, 0, 0, 32'h23_89_AB_1D);
    check("w2 ready", 64'(ready), 64'h0);
    check_state("w2");
    step(1, 0, 0, 32'hAB_FC_C4_0E);
    check_state("w2 drop");
    step(0, 1, 0, '0);
    check("r2 dout", 64'(dout), 64'hA234);
    check_state("r2");

    // Fill to full, dropped write, two reads
    step(1, 0, 0, 32'h87_12_92_CF);
    check("w3 full", 64'({full, ready}), 64'(2'b10));
    step(1, 0, 0, 32'h19_A3_B3_1F);
    check_state("w3 drop");
    step(0, 1, 0, '0);
    check("r3a dout", 64'(dout), 64'hAB1D);
    step(0, 1, 0, '0);
    check("r3b dout", 64'(dout), 64'h2389);
    check_state("r3b");

    // Refill and drain across the wrap point
    step(1, 0, 0, 32'h87_12_92_CF);
    check_state("refill");
    step(0, 1, 0, '0);
    check("wrap r1", 64'(dout), 64'h92CF);
    step(0, 1, 0, '0);
    check("wrap r2", 64'(dout), 64'h8712);
    step(0, 1, 0, '0);
    check("wrap r3", 64'(dout), 64'h92CF);
    step(0, 1, 0, '0);
    check("wrap r4", 64'(dout), 64'h8712);
    check("wrap empty", 64'({empty, valid}), 64'(2'b10));
    step(0, 1, 0, '0);
    check("wrap r5 hold", 64'(dout), 64'h8712);

    // Simultaneous read and write from count 4
    step(1, 0, 0, 32'h44_33_22_11);
    step(1, 1, 0, 32'h88_77_66_55);
    check("rw dout", 64'(dout), 64'h2211);
    check_state("rw");
    check("rw count6", 64'(q.size()), 64'd6);

    // Clear beats a same-cycle write
    step(1, 0, 1, 32'hDE_AD_BE_EF);
    check("clear flags", 64'({full, empty, ready, valid}), 64'(4'b0110));
    check("clear dout", 64'(dout), 64'h0);
    step(1, 0, 0, 32'h0D_0C_0B_0A);
    step(0, 1, 0, '0);
    check("post clear dout", 64'(dout), 64'h0B0A);

    async_reset("mid");
    check_state("after rst");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
           $urandom);
      check_state("rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/par_fifo.md
PAR_FIFO -- requirements
Module: par_fifo

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: storage depth DEPTH = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8: bits per word.
REQ-003 Parameter PAR_WRITE, default 4: words accepted per write; legal range 1..DEPTH.
REQ-004 Parameter PAR_READ, default 2: words delivered per read; legal range 1..DEPTH.
REQ-005 Port clk, input, 1: the block's one clock; all state changes occur on its rising edge.
REQ-006 Port rstn, input, 1: reset; asynchronous and active-low.
REQ-007 Port clear: input, 1 bit; synchronous flush.
REQ-008 Port wen: input, 1 bit; write request.
REQ-009 Port ren: input, 1 bit; read request.
REQ-010 Port din: input, PAR_WRITE*DATA_WIDTH bits; write data.
- Slice din[DATA_WIDTH-1:0] is the oldest word and enters first; higher slices follow in ascending order.
REQ-011 Port dout: output, PAR_READ*DATA_WIDTH bits; read data.
- Slice dout[DATA_WIDTH-1:0] is the oldest word; higher slices follow in ascending order.
REQ-012 Port full: output, 1 bit; high when count == DEPTH.
REQ-013 Port empty: output, 1 bit; high when count == 0.
REQ-014 Port ready: output, 1 bit; high when DEPTH - count >= PAR_WRITE.
REQ-015 Port valid: output, 1 bit; high when count >= PAR_READ.

Function
REQ-016 The block SHALL keep:
- a write pointer and a read pointer, each ADDR_WIDTH bits, wrapping modulo DEPTH;
- an occupancy count, ADDR_WIDTH+1 bits, range 0..DEPTH.
REQ-017 full, empty, ready and valid SHALL be combinational decodes of count only.
REQ-018 A write SHALL be accepted at a rising edge only when wen=1 and ready=1.
- On acceptance, the PAR_WRITE words are stored at wptr, wptr+1, ... (mod DEPTH).
- wptr advances by PAR_WRITE (mod DEPTH).
REQ-019 When wen=1 and ready=0, the write SHALL be dropped: storage, pointers and count are unchanged.
- No error flag is raised.
REQ-020 A read SHALL be accepted at a rising edge only when ren=1 and valid=1.
- On acceptance, dout is registered with the words at rptr, rptr+1, ... (mod DEPTH).
- rptr advances by PAR_READ (mod DEPTH).
REQ-021 When ren=1 and valid=0, the read SHALL be ignored: dout, pointers and count are unchanged.
REQ-022 dout SHALL hold its last value until the next accepted read.
- Read latency is one cycle: data appears at the edge that accepts the read.
REQ-023 Simultaneous accepted read and write SHALL both take effect in the same cycle.
- Acceptance of each uses the flags present before the edge.
- count updates by +PAR_WRITE-PAR_READ.
- The read returns only words stored before that edge.
REQ-024 count SHALL update by +PAR_WRITE on a write-only cycle, -PAR_READ on a read-only cycle, and 0 when neither is accepted.
REQ-025 clear=1 at a rising edge SHALL set wptr, rptr, count and dout to 0, overriding wen and ren in that cycle.
REQ-026 Wrap-around SHALL be seamless: a multi-word access that crosses address DEPTH-1 continues at address 0.
REQ-027 Storage contents need not be reset; only pointers, count and dout are reset.

Reset
REQ-028 rstn=0 SHALL immediately and asynchronously set wptr=0, rptr=0, count=0 and dout=0, regardless of clk.
- Flags during reset: empty=1, full=0, ready=1, valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored data.
- Operation resumes on the first rising edge after rstn returns to 1.

Verification (defaults 3/8/4/2)
REQ-030 Reset, then one-cycle write of din={A2,34,98,AC}:
- count=4; valid=1; ready=1; empty=0.
- Next read gives dout={98,AC}, then count=2.
REQ-031 With count=2, write {23,89,AB,1D}:
- count=6; ready=0.
- A following write of {AB,FC,C4,0E} is dropped and count stays 6.
- Next read gives dout={A2,34}, then count=4.
REQ-032 With count=4, write {87,12,92,CF}:
- count=8; full=1; ready=0.
- A further write of {19,A3,B3,1F} is dropped.
- The next two reads give {AB,1D} then {23,89}.
REQ-033 After refilling to full with {87,12,92,CF}, issue four reads:
- Order: {92,CF}, {87,12}, {92,CF}, {87,12}. This exercises pointer wrap.
- Afterwards empty=1 and valid=0.
- A fifth read leaves dout={87,12}.
REQ-034 With count=4, assert wen and ren together:
- count becomes 6.
- dout returns the two oldest words.
REQ-035 Assert clear with count=6 and wen=1 in the same cycle:
- Result: count=0, empty=1, dout=0, and the write is not stored.
- Pulsing rstn low between clock edges also zeros dout and count immediately.
